// File: rtl/stft_frame_sched_if.sv
// Bus between the STFT frame scheduler and its sample RAM / downstream window stage.
// The slave side is the scheduler. The master side drives samples and ready and observes the strobes.
interface stft_frame_sched_if #(
    parameter int AW = 8
);
    logic          ce_i;
    logic          ready_i;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic          rd_en_o;
    logic [AW-1:0] rd_addr_o;
    logic          frame_ce_o;
    logic          frame_start_o;
    logic          frame_last_o;
    logic          busy_o;
    logic          drop_o;
    logic          overrun_o;
    logic [15:0]   frame_count_o;

    modport slave (
        input  ce_i, ready_i,
        output wr_en_o, wr_addr_o, rd_en_o, rd_addr_o,
               frame_ce_o, frame_start_o, frame_last_o,
               busy_o, drop_o, overrun_o, frame_count_o
    );

    modport master (
        output ce_i, ready_i,
        input  wr_en_o, wr_addr_o, rd_en_o, rd_addr_o,
               frame_ce_o, frame_start_o, frame_last_o,
               busy_o, drop_o, overrun_o, frame_count_o
    );
endinterface

// File: rtl/stft_frame_sched.sv
// STFT frame scheduler: writes samples into a circular RAM and streams out the latest
// FFT_SIZE addresses (oldest first) after priming and every HOP_SIZE samples.
module stft_frame_sched #(
    parameter int FFT_SIZE = 256,
    parameter int HOP_SIZE = 128,
    parameter int AW       = $clog2(FFT_SIZE)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    stft_frame_sched_if.slave bus
);
    localparam int            CW        = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FFT_SIZE);
    localparam logic [CW-1:0] FILL_LAST = CW'(FFT_SIZE - 1);
    localparam logic [CW-1:0] HOP_LAST  = CW'(HOP_SIZE - 1);
    localparam logic [AW-1:0] IDX_LAST  = AW'(FFT_SIZE - 1);
    localparam logic [AW-1:0] ONE_A     = AW'(1);
    localparam logic [CW-1:0] ONE_C     = CW'(1);

    typedef enum logic [1:0] {PRIME, IDLE, READ} state_t;

    state_t        state_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_idx_q;
    logic [AW-1:0] pend_addr_q;
    logic [CW-1:0] fill_cnt_q;
    logic [CW-1:0] hop_cnt_q;
    logic [CW-1:0] wr_cnt_q;
    logic [CW-1:0] pend_wr_cnt_q;
    logic          pend_q;
    logic          frame_ce_q;
    logic          frame_start_q;
    logic          frame_last_q;
    logic          drop_q;
    logic          overrun_q;
    logic [15:0]   frame_count_q;

    logic          rd_en;
    logic          trig;
    logic          frame_end;
    logic          overrun_d;
    logic          drop_d;
    logic [AW-1:0] start_addr;
    logic [CW-1:0] wr_cnt_d;
    logic [CW-1:0] pend_wr_cnt_d;

    assign rd_en      = (state_q == READ) && bus.ready_i && !reset_i;
    assign trig       = bus.ce_i && ((state_q == PRIME) ? (fill_cnt_q == FILL_LAST)
                                                        : (hop_cnt_q == HOP_LAST));
    // The slot just written plus one is the oldest sample still in the RAM.
    assign start_addr = wr_ptr_q + ONE_A;
    assign frame_end  = rd_en && (rd_idx_q == IDX_LAST);
    assign drop_d     = trig && (state_q == READ) && pend_q;

    assign wr_cnt_d      = (bus.ce_i && (wr_cnt_q != FULL_CNT)) ? wr_cnt_q + ONE_C : wr_cnt_q;
    assign pend_wr_cnt_d = (bus.ce_i && (pend_wr_cnt_q != FULL_CNT)) ? pend_wr_cnt_q + ONE_C
                                                                      : pend_wr_cnt_q;
    // A write lands on frame index wr_cnt; unread unless this cycle's read already passed it.
    assign overrun_d  = bus.ce_i && (state_q == READ) &&
                        (wr_cnt_q >= ({1'b0, rd_idx_q} + CW'(rd_en)));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= PRIME;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rd_idx_q      <= '0;
            pend_addr_q   <= '0;
            fill_cnt_q    <= '0;
            hop_cnt_q     <= '0;
            wr_cnt_q      <= '0;
            pend_wr_cnt_q <= '0;
            pend_q        <= 1'b0;
            frame_ce_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            drop_q        <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_ce_q    <= rd_en;
            frame_start_q <= rd_en && (rd_idx_q == '0);
            frame_last_q  <= frame_end;
            overrun_q     <= overrun_d;
            drop_q        <= drop_d;
            if (frame_end) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            if (bus.ce_i) begin
                wr_ptr_q <= wr_ptr_q + ONE_A;
            end

            if (state_q == PRIME) begin
                hop_cnt_q <= '0;
                if (bus.ce_i) begin
                    fill_cnt_q <= fill_cnt_q + ONE_C;
                end
            end else if (bus.ce_i) begin
                hop_cnt_q <= trig ? '0 : hop_cnt_q + ONE_C;
            end

            case (state_q)
                PRIME, IDLE: begin
                    if (trig) begin
                        state_q  <= READ;
                        rd_ptr_q <= start_addr;
                        rd_idx_q <= '0;
                        wr_cnt_q <= '0;
                    end
                end
                READ: begin
                    wr_cnt_q      <= wr_cnt_d;
                    pend_wr_cnt_q <= pend_wr_cnt_d;
                    if (rd_en) begin
                        rd_ptr_q <= rd_ptr_q + ONE_A;
                        rd_idx_q <= rd_idx_q + ONE_A;
                    end
                    if (frame_end) begin
                        // A trigger arriving with the last read chains straight into the next frame.
                        if (pend_q) begin
                            rd_ptr_q <= pend_addr_q;
                            rd_idx_q <= '0;
                            wr_cnt_q <= pend_wr_cnt_d;
                            pend_q   <= 1'b0;
                        end else if (trig) begin
                            rd_ptr_q <= start_addr;
                            rd_idx_q <= '0;
                            wr_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (trig && !pend_q) begin
                        pend_q        <= 1'b1;
                        pend_addr_q   <= start_addr;
                        pend_wr_cnt_q <= '0;
                    end
                end
                default: state_q <= PRIME;
            endcase
        end
    end

    assign bus.wr_en_o       = bus.ce_i;
    assign bus.wr_addr_o     = wr_ptr_q;
    assign bus.rd_en_o       = rd_en;
    assign bus.rd_addr_o     = rd_ptr_q;
    assign bus.busy_o        = (state_q == READ);
    assign bus.frame_ce_o    = frame_ce_q;
    assign bus.frame_start_o = frame_start_q;
    assign bus.frame_last_o  = frame_last_q;
    assign bus.drop_o        = drop_q;
    assign bus.overrun_o     = overrun_q;
    assign bus.frame_count_o = frame_count_q;
endmodule

// File: tb/tb_stft_frame_sched.sv
// Directed bench for stft_frame_sched with FFT_SIZE=8, HOP_SIZE=4.
// The RAM model stores a running sample index, so a clean frame reads consecutive values.
module tb_stft_frame_sched;
    localparam int N  = 8;
    localparam int H  = 4;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    stft_frame_sched_if #(.AW(AW)) bus ();

    stft_frame_sched #(.FFT_SIZE(N), .HOP_SIZE(H), .AW(AW)) dut (
        .clk_i   (clk),
        .reset_i (srst),
        .bus     (bus)
    );

    // External sample RAM: synchronous read, read-first, value = sample index.
    logic [31:0] ram [N];
    logic [31:0] rd_data;
    logic [31:0] wr_data = '0;
    always @(posedge clk) begin
        if (bus.rd_en_o) rd_data <= ram[bus.rd_addr_o];
        if (bus.wr_en_o && !srst) begin
            ram[bus.wr_addr_o] <= wr_data;
            wr_data <= wr_data + 32'd1;
        end
    end

    // Frame monitor: records first value of each frame and whether it was well formed.
    int          nf = 0;
    logic [31:0] f_first [64];
    logic        f_ok [64];
    int          pos = 0;
    logic [31:0] cur_first = '0;
    logic        cur_ok = 1'b0;
    int          n_drop = 0;
    int          n_ovr = 0;
    int          n_fce = 0;
    always @(negedge clk) begin
        if (bus.drop_o) n_drop++;
        if (bus.overrun_o) n_ovr++;
        if (bus.frame_ce_o) begin
            n_fce++;
            if (bus.frame_start_o) begin
                cur_first = rd_data;
                pos = 0;
                cur_ok = 1'b1;
            end else begin
                pos++;
                if (rd_data !== cur_first + 32'(pos)) cur_ok = 1'b0;
            end
            if (bus.frame_last_o && nf < 64) begin
                f_first[nf] = cur_first;
                f_ok[nf] = cur_ok && (pos == N - 1);
                nf++;
            end
        end
    end

    int checks = 0;
    int bad = 0;

    task automatic cyc(input logic ce, input logic rdy);
        bus.ce_i = ce;
        bus.ready_i = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int nf0, d0, o0, f0;
        logic [31:0] base;
        srst = 1'b1;
        bus.ce_i = 1'b0;
        bus.ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.ce_i = 1'b1;
        #1;
        check("rst_wr_en", 32'(bus.wr_en_o), 1);
        check("rst_rd_en", 32'(bus.rd_en_o), 0);
        bus.ce_i = 1'b0;
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_frame_ce", 32'(bus.frame_ce_o), 0);
        check("rst_count", 32'(bus.frame_count_o), 0);
        srst = 1'b0;
        $display("step reset: done");

        // Prime: eight samples launch the first frame holding samples 0..7.
        base = wr_data;
        nf0 = nf;
        repeat (7) cyc(1'b1, 1'b1);
        check("prime_not_busy_early", 32'(bus.busy_o), 0);
        cyc(1'b1, 1'b1);
        check("prime_busy", 32'(bus.busy_o), 1);
        check("prime_rd_en", 32'(bus.rd_en_o), 1);
        repeat (12) cyc(1'b0, 1'b1);
        check("prime_frames", 32'(nf - nf0), 1);
        check("prime_first", f_first[nf0], base);
        check("prime_ok", 32'(f_ok[nf0]), 1);
        check("prime_count", 32'(bus.frame_count_o), 1);
        check("prime_idle", 32'(bus.busy_o), 0);
        $display("step prime: frames=%0d first=%0d", nf - nf0, f_first[nf0] - base);

        // Steady hop: one sample every 4th cycle, frames start at 4, 8, 12, ...
        nf0 = nf;
        d0 = n_drop;
        o0 = n_ovr;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b1);
            repeat (3) cyc(1'b0, 1'b1);
        end
        repeat (12) cyc(1'b0, 1'b1);
        check("hop_frames", 32'(nf - nf0), 10);
        for (int i = 0; i < 10; i++) begin
            check("hop_first", f_first[nf0 + i], base + 32'(4 + 4 * i));
            check("hop_ok", 32'(f_ok[nf0 + i]), 1);
        end
        check("hop_drop", 32'(n_drop - d0), 0);
        check("hop_ovr", 32'(n_ovr - o0), 0);
        check("hop_count", 32'(bus.frame_count_o), 11);
        $display("step hop: frames=%0d drops=%0d overruns=%0d", nf - nf0, n_drop - d0, n_ovr - o0);

        // Pending/drop: ready low for 20 cycles while a sample arrives every cycle.
        srst = 1'b1;
        cyc(1'b0, 1'b0);
        srst = 1'b0;
        check("pd_rst_count", 32'(bus.frame_count_o), 0);
        base = wr_data;
        nf0 = nf;
        d0 = n_drop;
        o0 = n_ovr;
        repeat (7) cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        check("pd_ovr_none", 32'(bus.overrun_o), 0);
        cyc(1'b1, 1'b0);
        check("pd_ovr_first", 32'(bus.overrun_o), 1);
        repeat (3) cyc(1'b1, 1'b0);
        check("pd_pend_nodrop", 32'(bus.drop_o), 0);
        repeat (4) cyc(1'b1, 1'b0);
        check("pd_drop", 32'(bus.drop_o), 1);
        repeat (12) cyc(1'b1, 1'b0);
        repeat (30) cyc(1'b0, 1'b1);
        check("pd_drops", 32'(n_drop - d0), 4);
        check("pd_ovrs", 32'(n_ovr - o0), 20);
        check("pd_frames", 32'(nf - nf0), 2);
        check("pd_pend_first", f_first[nf0 + 1], base + 32'd20);
        check("pd_pend_ok", 32'(f_ok[nf0 + 1]), 1);
        check("pd_count", 32'(bus.frame_count_o), 2);
        $display("step pend_drop: frames=%0d drops=%0d overruns=%0d", nf - nf0, n_drop - d0, n_ovr - o0);

        // Overrun: ready toggles while samples arrive every cycle.
        srst = 1'b1;
        cyc(1'b0, 1'b0);
        srst = 1'b0;
        nf0 = nf;
        d0 = n_drop;
        repeat (8) cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        check("ovr_c1", 32'(bus.overrun_o), 0);
        cyc(1'b1, 1'b0);
        check("ovr_c2", 32'(bus.overrun_o), 1);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b1);
            cyc(1'b1, 1'b0);
        end
        repeat (30) cyc(1'b0, 1'b1);
        check("ovr_frames", 32'(nf - nf0), 3);
        check("ovr_count", 32'(bus.frame_count_o), 3);
        check("ovr_drops", 32'(n_drop - d0), 2);
        $display("step overrun: frames=%0d drops=%0d", nf - nf0, n_drop - d0);

        // Simultaneous trigger and frame end: the 4th hop sample lands on the last read.
        srst = 1'b1;
        cyc(1'b0, 1'b0);
        srst = 1'b0;
        base = wr_data;
        nf0 = nf;
        d0 = n_drop;
        o0 = n_ovr;
        repeat (8) cyc(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1);
            cyc(1'b1, 1'b1);
        end
        check("sim_busy", 32'(bus.busy_o), 1);
        check("sim_rd_en", 32'(bus.rd_en_o), 1);
        check("sim_drop", 32'(bus.drop_o), 0);
        repeat (7) cyc(1'b0, 1'b1);
        check("sim_busy_late", 32'(bus.busy_o), 1);
        cyc(1'b0, 1'b1);
        check("sim_idle", 32'(bus.busy_o), 0);
        repeat (4) cyc(1'b0, 1'b1);
        check("sim_frames", 32'(nf - nf0), 2);
        check("sim_first0", f_first[nf0], base);
        check("sim_first1", f_first[nf0 + 1], base + 32'd4);
        check("sim_ok0", 32'(f_ok[nf0]), 1);
        check("sim_ok1", 32'(f_ok[nf0 + 1]), 1);
        check("sim_drops", 32'(n_drop - d0), 0);
        check("sim_ovrs", 32'(n_ovr - o0), 0);
        $display("step simultaneous: frames=%0d drops=%0d", nf - nf0, n_drop - d0);

        // Reset in the middle of a frame at rd_idx=3.
        srst = 1'b1;
        cyc(1'b0, 1'b0);
        srst = 1'b0;
        repeat (8) cyc(1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b1);
        srst = 1'b1;
        cyc(1'b0, 1'b1);
        srst = 1'b0;
        check("mid_rst_busy", 32'(bus.busy_o), 0);
        check("mid_rst_frame_ce", 32'(bus.frame_ce_o), 0);
        check("mid_rst_count", 32'(bus.frame_count_o), 0);
        f0 = n_fce;
        repeat (7) cyc(1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b1);
        check("mid_reprime_idle", 32'(bus.busy_o), 0);
        check("mid_no_strobes", 32'(n_fce - f0), 0);
        cyc(1'b1, 1'b1);
        check("mid_reprime_busy", 32'(bus.busy_o), 1);
        repeat (12) cyc(1'b0, 1'b1);
        check("mid_count", 32'(bus.frame_count_o), 1);
        $display("step mid_reset: strobes_before_reprime=%0d", n_fce - f0);

        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end
endmodule

// File: doc/stft_frame_sched.md
# stft_frame_sched

Frame scheduler for the STFT front end: tracks incoming sample strobes, writes each sample into an external FFT_SIZE-deep circular sample RAM, and after priming and every HOP_SIZE samples launches a readout of the most recent FFT_SIZE samples, oldest first. The readout is a paced, back-pressurable stream of addresses plus frame_start/frame_ce/frame_last strobes aligned to the RAM read data. It feeds windowfn → fftmain. It detects and reports frames lost to scheduling conflicts and samples overwritten before they were read.

## Interface
- FFT_SIZE, 256, frame length; power of two, ≥ 4
- HOP_SIZE, 128, samples between frame starts; 1 ≤ HOP_SIZE ≤ FFT_SIZE
- AW, $clog2(FFT_SIZE), RAM address width (derived)
- clk_i  in  1  single clock, all logic rising-edge
- reset_i  in  1  synchronous, active-high reset
- ce_i  in  1  input sample valid; at most one sample per cycle
- wr_en_o  out  1  RAM write enable; combinational, equal to ce_i
- wr_addr_o  out  AW  RAM write address; equal to wr_ptr
- rd_en_o  out  1  RAM read enable; (state==READ) && ready_i
- rd_addr_o  out  AW  RAM read address; equal to rd_ptr
- ready_i  in  1  downstream accepts a read this cycle
- frame_ce_o  out  1  RAM read data valid; rd_en_o delayed 1 cycle
- frame_start_o  out  1  with frame_ce_o on sample 0 of a frame
- frame_last_o  out  1  with frame_ce_o on sample FFT_SIZE-1
- busy_o  out  1  state==READ
- drop_o  out  1  1-cycle pulse: a frame trigger was discarded
- overrun_o  out  1  1-cycle pulse: an unread sample of the active frame was overwritten
- frame_count_o  out  16  frames completed, wraps mod 2^16

## Operation
- Sample RAM is external, 1-cycle synchronous read, read-first on same-address read/write.
- wr_ptr: AW bits, +1 on each ce_i, wraps naturally mod FFT_SIZE.
- FSM states: PRIME (reset state), IDLE, READ.
- PRIME: fill_cnt counts ce_i; the ce_i taking it to FFT_SIZE raises trigger. Go to READ next cycle. hop_cnt ← 0.
- IDLE/READ: hop_cnt counts ce_i; the ce_i taking it to HOP_SIZE raises trigger and sets hop_cnt ← 0.
- Trigger captures start = wr_ptr+1, the post-write pointer, which is the oldest sample.
- Trigger in IDLE (or leaving PRIME): next cycle READ with rd_ptr ← start, rd_idx ← 0, wr_cnt ← 0.
- Trigger in READ with no pending: pend ← 1, pend_addr ← start, pend_wr_cnt ← 0.
- Trigger in READ with pend already 1: the new trigger is discarded and drop_o pulses. The pending frame is kept.
- READ: each rd_en_o increments rd_ptr (wraps) and rd_idx. The rd_en_o with rd_idx==FFT_SIZE-1 ends the frame.
  - At frame end, if pend: stay READ, load rd_ptr ← pend_addr, rd_idx ← 0, wr_cnt ← pend_wr_cnt, pend ← 0.
  - Otherwise: go to IDLE.
- wr_cnt and pend_wr_cnt: +1 per ce_i, saturating at FFT_SIZE.
- Overrun: ce_i in READ with wr_cnt ≥ rd_idx + rd_en_o (pre-update values) pulses overrun_o next cycle. The frame continues and is not aborted.
- frame_count_o increments on the cycle frame_last_o is high.
- Trigger and frame end in the same cycle: the trigger sets pend first, and the frame end then consumes it. READ continues with no gap and no drop.

## Timing
- Reset values: state PRIME; wr_ptr, rd_ptr, fill_cnt, hop_cnt, rd_idx, counters 0; pend 0.
- Reset values of outputs: all registered outputs 0; frame_count_o 0.
- Combinational outputs under reset: wr_en_o follows ce_i; rd_en_o is 0.
- Trigger → first rd_en_o: 1 cycle if ready_i is high.
- rd_en_o → frame_ce_o/start/last: 1 cycle.
- Full back-to-back frame: exactly FFT_SIZE cycles of rd_en_o when ready_i is held high.
- reset_i mid-frame: everything returns to reset values next cycle, including priming. No strobes are emitted after reset deasserts until a new frame is read.
- ready_i low freezes rd_ptr and rd_idx; ce_i continues to be counted.

## Test plan
Bench parameters: FFT_SIZE=8, HOP_SIZE=4; RAM model holds value = sample index.
- Prime: ce_i for 8 cycles, ready_i=1. Required: frames read data 0..7, frame_start on 0, frame_last on 7, frame_count_o=1.
- Steady hop: ce_i every 4th cycle for 40 more samples. Required: frames start at indices 4, 8, 12, …, each 8 consecutive values; drop_o and overrun_o stay 0.
- Pending/drop: after prime, ready_i=0 for 20 cycles while ce_i is high every cycle. Required:
  - Triggers at samples 12 and 16 → first sets pend, second pulses drop_o.
  - Overrun_o pulses on the first write after prime.
- Overrun: after prime, ce_i every cycle and ready_i toggling 1/0. Required: overrun_o pulses once wr_cnt ≥ rd_idx; the frame still ends with frame_last_o.
- Simultaneous trigger + frame end: align the 4th hop sample with the last rd_en_o. Required: busy_o stays 1, no idle cycle between frames, drop_o=0.
- Reset mid-READ at rd_idx=3. Required next cycle: busy_o=0, frame_ce_o=0, frame_count_o=0, and 8 new samples are needed before the next frame.
